collision_detector_multi: RTL

//  Parametrised successor to the single-pair collision check. Tests the bird against
//  NUM_PIPES pipes and the screen walls, one pipe per clock, once per sample strobe.

---
 rtl/collision_detector_multi.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/collision_detector_multi.sv
// collision_detector_multi
// Scans the bird against NUM_PIPES pipes (one per clock) and the screen walls on
// each frame strobe, latches the first collision with its cause and pipe index,
// and holds off detection for a number of frames after a restart.
module collision_detector_multi #(
    parameter int NUM_PIPES    = 4,
    parameter int COORD_W      = 11,
    parameter int PIPE_W       = 70,
    parameter int GAP          = 80,
    parameter int BIRD_R       = 5,
    parameter int WALL_TOP     = 11,
    parameter int WALL_BOT     = 474,
    parameter int GRACE_FRAMES = 30,
    localparam int IDX_W = (NUM_PIPES > 1) ? $clog2(NUM_PIPES) : 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           sample,
    input  logic                           restart,
    input  logic [COORD_W-1:0]             bird_x,
    input  logic [COORD_W-1:0]             bird_y,
    input  logic [NUM_PIPES*COORD_W-1:0]   pipe_x,
    input  logic [NUM_PIPES*COORD_W-1:0]   pipe_y,
    input  logic [NUM_PIPES-1:0]           pipe_valid,
    output logic                           collision,
    output logic [1:0]                     cause,
    output logic [IDX_W-1:0]               hit_idx,
    output logic                           busy,
    output logic                           check_done,
    output logic                           grace
);

    // Two extra bits: one for sign, one headroom so x-PIPE_W etc. never wrap.
    localparam int SW    = COORD_W + 2;
    localparam int CNT_W = (GRACE_FRAMES > 0) ? $clog2(GRACE_FRAMES + 1) : 1;

    localparam logic signed [SW-1:0] PW_S  = SW'(PIPE_W);
    localparam logic signed [SW-1:0] GAP_S = SW'(GAP);
    localparam logic signed [SW-1:0] R_S   = SW'(BIRD_R);
    localparam logic signed [SW-1:0] WT_S  = SW'(WALL_TOP);
    localparam logic signed [SW-1:0] WB_S  = SW'(WALL_BOT);

    localparam logic [1:0] CAUSE_NONE = 2'd0;
    localparam logic [1:0] CAUSE_WALL = 2'd1;
    localparam logic [1:0] CAUSE_PIPE = 2'd2;

    typedef enum logic [1:0] {ARMED, SCAN, DEAD, GRACE} state_t;

    state_t                          state_q, state_d;
    logic [IDX_W-1:0]                idx_q, idx_d;
    logic [1:0]                      cause_q, cause_d;
    logic [IDX_W-1:0]                hit_idx_q, hit_idx_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic                            done_q, done_d;
    logic                            snap_en;

    logic [COORD_W-1:0]              bx_q, by_q;
    logic [NUM_PIPES*COORD_W-1:0]    px_q, py_q;
    logic [NUM_PIPES-1:0]            pv_q;

    logic [COORD_W-1:0]              cur_px, cur_py;
    logic                            cur_v;
    logic signed [SW-1:0]            bx_s, by_s, px_s, py_s;
    logic                            wall_hit, pipe_hit, last_pipe;

    function automatic logic signed [SW-1:0] to_s(input logic [COORD_W-1:0] v);
        return $signed({2'b00, v});
    endfunction

    // Select the snapshot pipe under test and evaluate wall/pipe overlap.
    always_comb begin
        cur_px = '0;
        cur_py = '0;
        cur_v  = 1'b0;
        for (int i = 0; i < NUM_PIPES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_px = px_q[i*COORD_W +: COORD_W];
                cur_py = py_q[i*COORD_W +: COORD_W];
                cur_v  = pv_q[i];
            end
        end
        bx_s      = to_s(bx_q);
        by_s      = to_s(by_q);
        px_s      = to_s(cur_px);
        py_s      = to_s(cur_py);
        wall_hit  = (by_s < WT_S) || (by_s > WB_S);
        pipe_hit  = cur_v
                    && (bx_s + R_S >= px_s - PW_S)
                    && (bx_s - R_S <= px_s)
                    && ((by_s + R_S >= py_s) || (by_s - R_S <= py_s - GAP_S));
        last_pipe = (idx_q == IDX_W'(NUM_PIPES - 1));
    end

    // Next-state logic; restart overrides every state, sample is only seen in ARMED/GRACE.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cause_d   = cause_q;
        hit_idx_d = hit_idx_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        snap_en   = 1'b0;
        if (restart) begin
            state_d   = GRACE;
            cnt_d     = CNT_W'(GRACE_FRAMES);
            cause_d   = CAUSE_NONE;
            hit_idx_d = '0;
        end else begin
            unique case (state_q)
                ARMED: begin
                    if (sample) begin
                        snap_en = 1'b1;
                        idx_d   = '0;
                        state_d = SCAN;
                    end
                end
                SCAN: begin
                    if ((idx_q == '0) && wall_hit) begin
                        state_d   = DEAD;
                        cause_d   = CAUSE_WALL;
                        hit_idx_d = '0;
                    end else if (pipe_hit) begin
                        state_d   = DEAD;
                        cause_d   = CAUSE_PIPE;
                        hit_idx_d = idx_q;
                    end else if (last_pipe) begin
                        state_d = ARMED;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                DEAD: begin
                    state_d = DEAD;
                end
                GRACE: begin
                    // A zero counter only occurs when GRACE_FRAMES is 0.
                    if (cnt_q == '0) begin
                        state_d = ARMED;
                    end else if (sample) begin
                        cnt_d = cnt_q - 1'b1;
                        if (cnt_q == CNT_W'(1)) begin
                            state_d = ARMED;
                        end
                    end
                end
                default: state_d = ARMED;
            endcase
        end
    end

    // State, result and snapshot registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ARMED;
            idx_q     <= '0;
            cause_q   <= CAUSE_NONE;
            hit_idx_q <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            bx_q      <= '0;
            by_q      <= '0;
            px_q      <= '0;
            py_q      <= '0;
            pv_q      <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cause_q   <= cause_d;
            hit_idx_q <= hit_idx_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            if (snap_en) begin
                bx_q <= bird_x;
                by_q <= bird_y;
                px_q <= pipe_x;
                py_q <= pipe_y;
                pv_q <= pipe_valid;
            end
        end
    end

    assign collision  = (state_q == DEAD);
    assign busy       = (state_q == SCAN);
    assign grace      = (state_q == GRACE);
    assign cause      = cause_q;
    assign hit_idx    = hit_idx_q;
    assign check_done = done_q;

endmodule
